// File: rtl/audio_link_encoder.sv
// Transmit side of the inter-FPGA stereo audio link: serialises L/R sample pairs into
// back-to-back 40-bit frames (0xAA sync, left, right; MSB first) on sck/ws/sd.
module audio_link_encoder #(
    parameter int CLKDIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        sck,
    output logic        ws,
    output logic        sd,
    output logic        frame_start,
    output logic        underrun
);

    localparam int               DIV_W     = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(CLKDIV - 1);
    localparam logic [5:0]       LAST_BIT  = 6'd39;
    localparam logic [5:0]       PRE_RIGHT = 6'd23;
    localparam logic [7:0]       SYNC      = 8'hAA;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [5:0]        bit_q, bit_d;
    logic [39:0]       shift_q, shift_d;
    logic              sck_q, sck_d;
    logic              ws_q, ws_d;
    logic              frame_start_q, frame_start_d;
    logic              underrun_q, underrun_d;
    logic              hold_full_q, hold_full_d;
    logic [31:0]       hold_data_q, hold_data_d;
    logic [31:0]       last_pair_q, last_pair_d;
    logic              accept;
    logic              load;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        div_d         = div_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        sck_d         = sck_q;
        ws_d          = ws_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        hold_full_d   = hold_full_q;
        hold_data_d   = hold_data_q;
        last_pair_d   = last_pair_q;
        load          = 1'b0;

        accept = sample_valid && !hold_full_q;
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = {left_in, right_in};
        end

        case (state_q)
            S_IDLE: begin
                sck_d = 1'b0;
                ws_d  = 1'b0;
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (div_q == DIV_TC) begin
                    div_d = '0;
                    sck_d = !sck_q;
                    // Data advances only on the falling edge so sd is centred on each rise.
                    if (sck_q) begin
                        if (bit_q == LAST_BIT) begin
                            load = 1'b1;
                        end else begin
                            bit_d   = bit_q + 6'd1;
                            shift_d = {shift_q[38:0], 1'b0};
                            ws_d    = (bit_q >= PRE_RIGHT);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A frame with nothing fresh in the holding register repeats the previous pair.
        if (load) begin
            bit_d         = '0;
            div_d         = '0;
            ws_d          = 1'b0;
            frame_start_d = 1'b1;
            if (hold_full_q) begin
                shift_d     = {SYNC, hold_data_q};
                last_pair_d = hold_data_q;
                hold_full_d = 1'b0;
            end else begin
                shift_d    = {SYNC, last_pair_q};
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the holding data is not reset; hold_full qualifies it, so its contents never matter while empty.
        hold_data_q <= hold_data_d;
        if (rst) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            sck_q         <= 1'b0;
            ws_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            hold_full_q   <= 1'b0;
            last_pair_q   <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            sck_q         <= sck_d;
            ws_q          <= ws_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_full_q   <= hold_full_d;
            last_pair_q   <= last_pair_d;
        end
    end

    assign sample_ready = !hold_full_q;
    assign sck          = sck_q;
    assign ws           = ws_q;
    assign sd           = shift_q[39];
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_link_encoder.sv
// Directed bench for audio_link_encoder: a CLKDIV=4 and a CLKDIV=3 instance, each watched by a
// reference link decoder that captures sd on sck rises and checks framing, ws and timing.
module tb_audio_link_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] l0, r0, l1, r1;
    logic        v0, v1;
    logic        rdy0, sck0, ws0, sd0, fs0, ur0;
    logic        rdy1, sck1, ws1, sd1, fs1, ur1;

    audio_link_encoder #(.CLKDIV(4)) dut (
        .clk(clk), .rst(rst), .left_in(l0), .right_in(r0), .sample_valid(v0),
        .sample_ready(rdy0), .sck(sck0), .ws(ws0), .sd(sd0),
        .frame_start(fs0), .underrun(ur0)
    );

    audio_link_encoder #(.CLKDIV(3)) dut3 (
        .clk(clk), .rst(rst), .left_in(l1), .right_in(r1), .sample_valid(v1),
        .sample_ready(rdy1), .sck(sck1), .ws(ws1), .sd(sd1),
        .frame_start(fs1), .underrun(ur1)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference decoder / link monitor ----------------
    logic        sck_a[2], ws_a[2], sd_a[2], fs_a[2], ur_a[2], v_a[2], rdy_a[2];
    always_comb begin
        sck_a[0] = sck0; ws_a[0] = ws0; sd_a[0] = sd0; fs_a[0] = fs0; ur_a[0] = ur0;
        v_a[0]   = v0;   rdy_a[0] = rdy0;
        sck_a[1] = sck1; ws_a[1] = ws1; sd_a[1] = sd1; fs_a[1] = fs1; ur_a[1] = ur1;
        v_a[1]   = v1;   rdy_a[1] = rdy1;
    end

    logic [31:0] got0[$];
    logic [31:0] got1[$];
    logic        prev_sck[2], prev_sd[2], prev_ws[2], rise_v[2], fs_v[2];
    logic [39:0] win[2];
    int          bitidx[2], since_sd[2], since_rise[2], since_fs[2];
    int          stab_err[2], ws_err[2], hdr_err[2], per_err[2], gap_err[2], pulse_err[2];
    int          fs_cnt[2], ur_cnt[2], acc_cnt[2];
    int          mcd;
    logic        m_rise, m_fall;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mcd = (k == 0) ? 4 : 3;
            if (rst) begin
                bitidx[k] = -1;   since_sd[k] = 1000; since_rise[k] = 1000; since_fs[k] = 0;
                rise_v[k] = 1'b0; fs_v[k] = 1'b0;     win[k] = '0;
                stab_err[k] = 0;  ws_err[k] = 0;      hdr_err[k] = 0;  per_err[k] = 0;
                gap_err[k] = 0;   pulse_err[k] = 0;   fs_cnt[k] = 0;   ur_cnt[k] = 0;
                acc_cnt[k] = 0;
                if (k == 0) got0.delete(); else got1.delete();
            end else begin
                m_rise = sck_a[k] && !prev_sck[k];
                m_fall = !sck_a[k] && prev_sck[k];
                since_sd[k]++; since_rise[k]++; since_fs[k]++;
                if (v_a[k] && rdy_a[k]) acc_cnt[k]++;
                if (ur_a[k]) begin
                    ur_cnt[k]++;
                    if (!fs_a[k]) pulse_err[k]++;
                end
                if (fs_a[k]) begin
                    fs_cnt[k]++;
                    if (fs_v[k] && since_fs[k] != 80 * mcd) gap_err[k]++;
                    fs_v[k] = 1'b1; since_fs[k] = 0; bitidx[k] = 0;
                end
                if (sd_a[k] != prev_sd[k]) begin
                    if (since_rise[k] < mcd || !(m_fall || fs_a[k])) stab_err[k]++;
                    since_sd[k] = 0;
                end
                if (ws_a[k] != prev_ws[k] && !(m_fall || fs_a[k])) ws_err[k]++;
                if (m_rise) begin
                    if (since_sd[k] < mcd) stab_err[k]++;
                    if (rise_v[k] && since_rise[k] != 2 * mcd) per_err[k]++;
                    rise_v[k] = 1'b1; since_rise[k] = 0;
                    if (bitidx[k] >= 0) begin
                        win[k] = {win[k][38:0], sd_a[k]};
                        if (ws_a[k] != (bitidx[k] >= 24)) ws_err[k]++;
                        bitidx[k]++;
                        if (bitidx[k] == 40) begin
                            if (win[k][39:32] != 8'hAA) hdr_err[k]++;
                            if (k == 0) got0.push_back(win[k][31:0]);
                            else        got1.push_back(win[k][31:0]);
                            bitidx[k] = -1;
                        end
                    end
                end
            end
            prev_sck[k] = sck_a[k];
            prev_sd[k]  = sd_a[k];
            prev_ws[k]  = ws_a[k];
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] got_at(input int k, input int i);
        if (k == 0) return (i < got0.size()) ? got0[i] : 32'hxxxx_xxxx;
        return (i < got1.size()) ? got1[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Returns just after the accepting edge.
    task automatic push(input int k, input logic [15:0] l, input logic [15:0] r);
        int n;
        n = 0;
        if (k == 0) begin l0 = l; r0 = r; v0 = 1'b1; end
        else        begin l1 = l; r1 = r; v1 = 1'b1; end
        while (((k == 0) ? rdy0 : rdy1) == 1'b0 && n < 1000) begin
            step();
            n++;
        end
        check("push_ready_wait", (n < 1000), 1'b1);
        step();
        if (k == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic wait_dec(input int k, input int n, input int budget);
        int c;
        c = 0;
        while (((k == 0) ? got0.size() : got1.size()) < n && c < budget) begin
            step();
            c++;
        end
        check("frames_decoded", (((k == 0) ? got0.size() : got1.size()) >= n), 1'b1);
    endtask

    task automatic check_link(input string tag, input int k);
        check({tag, "_stab"},  stab_err[k],  0);
        check({tag, "_ws"},    ws_err[k],    0);
        check({tag, "_hdr"},   hdr_err[k],   0);
        check({tag, "_per"},   per_err[k],   0);
        check({tag, "_gap"},   gap_err[k],   0);
        check({tag, "_pulse"}, pulse_err[k], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int n;
        int ws_hi;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        l0 = '0; r0 = '0; l1 = '0; r1 = '0;
        repeat (3) step();
        check("rst_sck",   sck0, 1'b0);
        check("rst_sd",    sd0,  1'b0);
        check("rst_ws",    ws0,  1'b0);
        check("rst_fs",    fs0,  1'b0);
        check("rst_ur",    ur0,  1'b0);
        check("rst_ready", rdy0, 1'b1);
        rst = 1'b0;
        step();

        // T1: single pair, latency from accept to frame_start and first sck rise
        push(0, 16'h1234, 16'hABCD);
        check("t1_fs_wait",  fs0,  1'b0);
        check("t1_rdy_full", rdy0, 1'b0);
        step();
        check("t1_fs",    fs0,  1'b1);
        check("t1_sd0",   sd0,  1'b1);
        check("t1_sck0",  sck0, 1'b0);
        check("t1_ws0",   ws0,  1'b0);
        check("t1_rdy",   rdy0, 1'b1);
        n = 0;
        while (!sck0 && n < 20) begin
            step();
            n++;
        end
        check("t1_rise_lat", n, 4);
        wait_dec(0, 1, 600);
        check("t1_data", got_at(0, 0), 32'h1234ABCD);

        // T3: no new data -> two repeated frames, each flagged as underrun
        wait_dec(0, 3, 1500);
        check("t3_rep1",  got_at(0, 1), 32'h1234ABCD);
        check("t3_rep2",  got_at(0, 2), 32'h1234ABCD);
        check("t3_ur",    ur_cnt[0], 2);
        check("t3_fscnt", fs_cnt[0], 3);
        // Fresh pair accepted mid-frame is used for the following frame
        push(0, 16'hC0DE, 16'h0BAD);
        wait_dec(0, 4, 800);
        check("t3_new",    got_at(0, 3), 32'hC0DE0BAD);
        check("t3_ur_new", ur_cnt[0], 2);

        // T4: ws high for exactly 16 of the 40 bit periods of a frame
        n = 0;
        while (!fs0 && n < 800) begin
            step();
            n++;
        end
        check("t4_fs_seen", fs0, 1'b1);
        ws_hi = 0;
        for (int i = 0; i < 320; i++) begin
            if (ws0) ws_hi++;
            step();
        end
        check("t4_ws_hi_clks", ws_hi, 16 * 8);
        check_link("t4", 0);

        // T2: three pairs back-to-back with valid held high
        do_reset();
        push(0, 16'h0F0F, 16'hF0F0);
        push(0, 16'hAA55, 16'h55AA);
        push(0, 16'hFFFF, 16'h0001);
        wait_dec(0, 3, 1500);
        check("t2_p0",    got_at(0, 0), 32'h0F0FF0F0);
        check("t2_p1",    got_at(0, 1), 32'hAA5555AA);
        check("t2_p2",    got_at(0, 2), 32'hFFFF0001);
        check("t2_ur",    ur_cnt[0],  0);
        check("t2_acc",   acc_cnt[0], 3);
        check("t2_fscnt", fs_cnt[0],  3);
        check_link("t2", 0);

        // T5: reset while bit 30 is on the line, then recover
        do_reset();
        push(0, 16'h5A5A, 16'hFFFF);
        n = 0;
        while (bitidx[0] != 31 && n < 800) begin
            step();
            n++;
        end
        check("t5_at_bit30", bitidx[0], 31);
        check("t5_pre_sck", sck0, 1'b1);
        check("t5_pre_sd",  sd0,  1'b1);
        rst = 1'b1;
        step();
        check("t5_sck",   sck0, 1'b0);
        check("t5_sd",    sd0,  1'b0);
        check("t5_ws",    ws0,  1'b0);
        check("t5_ready", rdy0, 1'b1);
        rst = 1'b0;
        step();
        push(0, 16'h0246, 16'h8ACE);
        wait_dec(0, 1, 600);
        check("t5_data", got_at(0, 0), 32'h02468ACE);
        check_link("t5", 0);

        // T6: CLKDIV=3 instance
        do_reset();
        push(1, 16'h7E57, 16'h3C3C);
        push(1, 16'h0001, 16'h8000);
        wait_dec(1, 2, 800);
        check("t6_p0", got_at(1, 0), 32'h7E573C3C);
        check("t6_p1", got_at(1, 1), 32'h00018000);
        check("t6_ur", ur_cnt[1], 0);
        check_link("t6", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
